wb_writeback_regfile: RTL
=========================

// Module: wb_writeback_regfile
// PURPOSE
//  Consumer end of the WB pipeline register: takes the WB-stage control/data outputs, formats load
//  data, selects the writeback value and commits it to the 32x32 integer register file. Provides
//  the two ID-stage read ports with write-through bypass. Sits between the WB stage register and decode.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  NREGS     32  architectural registers; x0 hardwired to zero
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-high
//  wb_valid          in   1   WB slot holds a real instruction (0 for bubble/flush)
//  wb_regwrite       in   1   write enable from WB control
//  wb_regwrsrc       in   2   writeback source select (ALU/MEM/IMM/PC4)
//  wb_load_funct3    in   3   load type for MEM source (LB/LH/LW/LBU/LHU)
//  wb_pc             in   32  instruction PC
//  wb_rd             in   5   destination register
//  wb_aluresult      in   32  ALU result; bits[1:0] also the load byte offset
//  wb_imm            in   32  immediate (LUI)
//  wb_mem_read_data  in   32  raw aligned memory word
//  rs1_addr,rs2_addr in   5   ID read addresses
//  rs1_data,rs2_data out  32  ID read data (combinational)
//  wb_wen            out  1   commit strobe this cycle (for forwarding unit)
//  wb_wdata          out  32  selected writeback value (for forwarding unit)
//  instret           out  64  retired count (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset: all 31 writable registers <= 0 asynchronously; rs*_data read 0; instret <= 0.
//  - wb_wen = wb_valid & wb_regwrite & (wb_rd != 0); combinational.
//  - wb_wdata by wb_regwrsrc: ALU->aluresult; MEM->formatted load; IMM->imm; PC4->pc+4, mod 2^32 (wraps).
//  - Load format, off=aluresult[1:0]: LB/LBU byte[off] sign/zero-extended; LH/LHU halfword[off[1]]
//    sign/zero-extended, off[0] ignored; LW and any undefined funct3 -> full word, offset ignored.
//  - Commit: at posedge clk, if wb_wen, regs[wb_rd] <= wb_wdata. Single cycle, no backpressure.
//  - Read: addr 0 -> 0; else if wb_wen and addr==wb_rd -> wb_wdata (write-through, same cycle);
//    else regs[addr]. Both ports may hit same register, each bypassed independently.
//  - wb_rd==0 with regwrite: no write, wb_wen=0, x0 stays 0.
//  - wb_valid=0 suppresses write regardless of wb_regwrite.
//  - rst asserted mid-operation: pending write discarded; rst dominates clk.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: 64-bit instret increments by 1 at posedge when wb_valid=1 (independent
//   of regwrite; stores/branches count); wraps 2^64-1 -> 0; reset 0.
//  Not defined: instret port absent, no counter logic.
// STRUCTURE
//  - Shared include: REGWRSRC_BUS width and codes ALU=0, MEM=1, IMM=2, PC4=3; load funct3 codes
//    LB=000, LH=001, LW=010, LBU=100, LHU=101.
//  - Sub-module wb_load_align: combinational raw word + offset + funct3 -> 32-bit formatted load.
//  - Register array + bypass read mux + source mux + optional counter in this module.
// TESTING
//  1 rst pulse then read x1..x31 -> all 0; write x5 with regwrite=1 -> rs1_data(x5) new value next cycle.
//  2 ALU src, rd=7, alu=0x1234, rs2_addr=7 same cycle -> rs2_data=0x1234 (bypass), wb_wen=1.
//  3 MEM src, raw=0x80FF7F01: LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x7F; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x7F01.
//  4 rd=0, regwrite=1, alu=0xDEAD -> wb_wen=0, rs1_data(x0)=0 after edge.
//  5 PC4 src, pc=0xFFFFFFFC -> wb_wdata=0; wb_valid=0 with regwrite=1 -> register unchanged.
//  6 WB_RETIRE_CNT_EN: 10 cycles, valid on 7 -> instret=7; rst mid-write -> target reg 0, instret 0.

Source files
------------

// File: rtl/wb_writeback_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_writeback_regfile_pkg
//   Shared definitions for the writeback / register-file slice: datapath
//   sizes, writeback-source select codes and load funct3 encodings.
//   No ports (package).
// ---------------------------------------------------------------------------
package wb_writeback_regfile_pkg;

    localparam int XLEN        = 32;
    localparam int NREGS       = 32;
    localparam int REGADDR_W   = 5;
    localparam int REGWRSRC_W  = 2;   // width of the REGWRSRC bus

    // Writeback source select
    typedef enum logic [REGWRSRC_W-1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_IMM = 2'd2,
        SRC_PC4 = 2'd3
    } regwrsrc_e;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_writeback_regfile_load_align.sv
// ---------------------------------------------------------------------------
// wb_load_align
//   Combinational load formatter. Picks the byte or halfword addressed by the
//   low address bits out of the raw aligned memory word and sign/zero
//   extends it according to the load funct3.
// Ports
//   raw     in  32  raw aligned memory word
//   offset  in  2   byte offset within the word (address[1:0])
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   data    out 32  formatted load value
// ---------------------------------------------------------------------------
module wb_load_align
    import wb_writeback_regfile_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        byte_sel = raw[7:0];
        case (offset)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
    end

    // Halfword loads use only offset[1]; offset[0] is ignored.
    assign half_sel = offset[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data = raw;  // LW and undefined funct3: whole word, offset ignored
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/wb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// wb_writeback_regfile
//   Consumer end of the WB pipeline register. Selects the writeback value
//   (ALU / formatted load / immediate / PC+4), commits it to the 32x32
//   integer register file (x0 hardwired to zero) and serves the two ID-stage
//   read ports with same-cycle write-through bypass.
//   Optional feature macro: WB_RETIRE_CNT_EN adds a 64-bit retired
//   instruction counter on port instret.
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   wb_valid            WB slot holds a real instruction
//   wb_regwrite         register write enable from WB control
//   wb_regwrsrc [1:0]   writeback source (ALU/MEM/IMM/PC4)
//   wb_load_funct3[2:0] load type for MEM source
//   wb_pc, wb_rd, wb_aluresult, wb_imm, wb_mem_read_data  WB payload
//   rs1_addr, rs2_addr  ID read addresses
//   rs1_data, rs2_data  ID read data (combinational)
//   wb_wen, wb_wdata    commit strobe / value (for the forwarding unit)
//   instret   [63:0]    retired count (WB_RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module wb_writeback_regfile
    import wb_writeback_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic                  wb_regwrite,
    input  logic [1:0]            wb_regwrsrc,
    input  logic [2:0]            wb_load_funct3,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic [REGADDR_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]       wb_aluresult,
    input  logic [XLEN-1:0]       wb_imm,
    input  logic [XLEN-1:0]       wb_mem_read_data,
    input  logic [REGADDR_W-1:0]  rs1_addr,
    input  logic [REGADDR_W-1:0]  rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wb_wen,
    output logic [XLEN-1:0]       wb_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           instret
`endif
);

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] regs [NREGS];

    // -----------------------------------------------------------------------
    // Load formatting
    // -----------------------------------------------------------------------
    wb_load_align u_load_align (
        .raw    (wb_mem_read_data),
        .offset (wb_aluresult[1:0]),
        .funct3 (wb_load_funct3),
        .data   (load_data)
    );

    // -----------------------------------------------------------------------
    // Commit strobe and writeback source select
    // -----------------------------------------------------------------------
    assign wb_wen = wb_valid & wb_regwrite & (wb_rd != '0);

    always_comb begin
        wb_wdata = wb_aluresult;
        case (regwrsrc_e'(wb_regwrsrc))
            SRC_ALU: wb_wdata = wb_aluresult;
            SRC_MEM: wb_wdata = load_data;
            SRC_IMM: wb_wdata = wb_imm;
            SRC_PC4: wb_wdata = wb_pc + 32'd4;   // wraps mod 2^32
            default: wb_wdata = wb_aluresult;
        endcase
    end

    // -----------------------------------------------------------------------
    // Register array. Entry 0 is never written and never read out, so x0
    // stays zero.
    // -----------------------------------------------------------------------
    // NOTE: the array is cleared in the async reset branch because the
    // architecture requires all registers to read zero after reset; this
    // forces flops rather than a RAM macro, which is acceptable at 32x32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wen) begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples pre-edge values.
            regs[wb_rd] <= wb_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with write-through bypass (each port independent)
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_wen && (rs1_addr == wb_rd)) begin
            rs1_data = wb_wdata;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_wen && (rs2_addr == wb_rd)) begin
            rs2_data = wb_wdata;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // -----------------------------------------------------------------------
    // Retired instruction counter: every valid WB slot retires, whether or
    // not it writes a register. Wraps naturally at 2^64.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (wb_valid) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule
